branch_predict_unit: RTL and testbench

//  Branch resolution + prediction unit for the RV32IM core, next generation of the combinational branch comparator.
//  - Resolves BEQ/BNE/BLT/BGE/BLTU/BGEU with a one-cycle registered result.
//  - Holds a PC-indexed table of 2-bit saturating counters (bimodal BHT) that gives fetch a taken/not-taken prediction.
//  - Flags mispredictions so the core can redirect, and keeps a saturating mispredict statistics counter.

---
 rtl/branch_predict_unit.sv | 117 +++++++++++
 tb/tb_branch_predict_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Branch resolution with a registered result, a bimodal 2-bit-counter BHT for fetch prediction,
// and a saturating mispredict counter.
module branch_predict_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BHT_DEPTH  = 64,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_pred_pc,
  output logic                  o_pred_take,
  input  logic                  i_valid,
  input  logic                  i_branch,
  input  logic [2:0]            i_branch_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic                  i_pred_take,
  input  logic                  i_flush,
  output logic                  o_valid,
  output logic                  o_take,
  output logic                  o_mispredict,
  output logic                  o_illegal,
  output logic [CNT_WIDTH-1:0]  o_mispred_count
);

  localparam int unsigned IdxW = $clog2(BHT_DEPTH);

  logic [1:0]           r_bht [BHT_DEPTH];
  logic                 r_valid;
  logic                 r_take;
  logic                 r_mispredict;
  logic                 r_illegal;
  logic [CNT_WIDTH-1:0] r_mispred_count;

  logic [IdxW-1:0] w_pred_idx;
  logic [IdxW-1:0] w_res_idx;
  logic            w_eq;
  logic            w_lt;
  logic            w_ltu;
  logic            w_cond;
  logic            w_illegal;
  logic            w_accept;
  logic            w_take;
  logic            w_mispredict;
  logic            w_update;
  logic [1:0]      w_ctr_cur;
  logic [1:0]      w_ctr_next;

  assign w_pred_idx  = i_pred_pc[IdxW+1:2];
  assign w_res_idx   = i_pc[IdxW+1:2];
  // Plain array read: a same-cycle update is only visible after the edge.
  assign o_pred_take = r_bht[w_pred_idx][1];

  always_comb begin
    w_eq  = (i_a == i_b);
    w_lt  = ($signed(i_a) < $signed(i_b));
    w_ltu = (i_a < i_b);
    w_cond = 1'b0;
    case (i_branch_op)
      3'b000:  w_cond = w_eq;
      3'b001:  w_cond = !w_eq;
      3'b100:  w_cond = w_lt;
      3'b101:  w_cond = !w_lt;
      3'b110:  w_cond = w_ltu;
      3'b111:  w_cond = !w_ltu;
      default: w_cond = 1'b0;
    endcase

    w_illegal    = i_branch && (i_branch_op[2:1] == 2'b01);
    w_accept     = i_valid && !i_flush;
    w_take       = i_branch && !w_illegal && w_cond;
    // A non-branch resolves not-taken, so a taken prediction for it is a mispredict.
    w_mispredict = !w_illegal && (w_take != i_pred_take);
    w_update     = w_accept && i_branch && !w_illegal;

    w_ctr_cur  = r_bht[w_res_idx];
    w_ctr_next = w_ctr_cur;
    if (w_take) begin
      if (w_ctr_cur != 2'b11) w_ctr_next = w_ctr_cur + 2'b01;
    end else begin
      if (w_ctr_cur != 2'b00) w_ctr_next = w_ctr_cur - 2'b01;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(BHT_DEPTH); i++) begin
        r_bht[i] <= 2'b01;
      end
      r_valid         <= 1'b0;
      r_take          <= 1'b0;
      r_mispredict    <= 1'b0;
      r_illegal       <= 1'b0;
      r_mispred_count <= '0;
    end else begin
      r_valid      <= w_accept;
      r_take       <= w_accept && w_take;
      r_mispredict <= w_accept && w_mispredict;
      r_illegal    <= w_accept && w_illegal;
      if (w_accept && w_mispredict && (r_mispred_count != {CNT_WIDTH{1'b1}})) begin
        r_mispred_count <= r_mispred_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      if (w_update) begin
        r_bht[w_res_idx] <= w_ctr_next;
      end
    end
  end

  assign o_valid         = r_valid;
  assign o_take          = r_take;
  assign o_mispredict    = r_mispredict;
  assign o_illegal       = r_illegal;
  assign o_mispred_count = r_mispred_count;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench: stimulus pushes hand-computed results, a negedge monitor pops and compares.
module tb_branch_predict_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_pred_pc;
  logic        i_valid;
  logic        i_branch;
  logic [2:0]  i_branch_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic [31:0] i_pc;
  logic        i_pred_take;
  logic        i_flush;

  logic        o_pred_take, o_valid, o_take, o_mispredict, o_illegal;
  logic [15:0] o_mispred_count;
  logic        o2_pred_take, o2_valid, o2_take, o2_mispredict, o2_illegal;
  logic [1:0]  o2_mispred_count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic take;
    logic mis;
    logic ill;
    int   cnt;
  } exp_t;
  exp_t q[$];

  always #5 i_clk = ~i_clk;

  branch_predict_unit dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pred_pc(i_pred_pc), .o_pred_take(o_pred_take),
    .i_valid(i_valid), .i_branch(i_branch), .i_branch_op(i_branch_op), .i_a(i_a), .i_b(i_b),
    .i_pc(i_pc), .i_pred_take(i_pred_take), .i_flush(i_flush), .o_valid(o_valid),
    .o_take(o_take), .o_mispredict(o_mispredict), .o_illegal(o_illegal),
    .o_mispred_count(o_mispred_count)
  );

  // Narrow-counter instance shares all stimulus to exercise count saturation.
  branch_predict_unit #(.CNT_WIDTH(2)) dut2 (
    .i_clk(i_clk), .i_rst(i_rst), .i_pred_pc(i_pred_pc), .o_pred_take(o2_pred_take),
    .i_valid(i_valid), .i_branch(i_branch), .i_branch_op(i_branch_op), .i_a(i_a), .i_b(i_b),
    .i_pc(i_pc), .i_pred_take(i_pred_take), .i_flush(i_flush), .o_valid(o2_valid),
    .o_take(o2_take), .o_mispredict(o2_mispredict), .o_illegal(o2_illegal),
    .o_mispred_count(o2_mispred_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge i_clk) begin
    if (o_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 32'(o_valid), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("take", 32'(o_take), 32'(e.take));
        chk("mispredict", 32'(o_mispredict), 32'(e.mis));
        chk("illegal", 32'(o_illegal), 32'(e.ill));
        chk("count", 32'(o_mispred_count), 32'(e.cnt));
        chk("count_w2", 32'(o2_mispred_count), 32'((e.cnt > 3) ? 3 : e.cnt));
      end
    end
  end

  task automatic idle();
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_branch = 1'b0;
    i_flush = 1'b0;
  endtask

  task automatic issue(input logic br, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc, input logic pred,
                       input logic flush, input logic e_take, input logic e_mis,
                       input logic e_ill, input int e_cnt);
    exp_t e;
    @(posedge i_clk);
    #1;
    i_valid = 1'b1;
    i_branch = br;
    i_branch_op = op;
    i_a = a;
    i_b = b;
    i_pc = pc;
    i_pred_take = pred;
    i_flush = flush;
    if (!flush) begin
      e.take = e_take;
      e.mis = e_mis;
      e.ill = e_ill;
      e.cnt = e_cnt;
      q.push_back(e);
    end
  endtask

  task automatic chk_pred(input string name, input logic [31:0] pc, input logic exp);
    i_pred_pc = pc;
    #1;
    chk(name, 32'(o_pred_take), 32'(exp));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_take"}, 32'(o_take), 32'd0);
    chk({tag, "_mis"}, 32'(o_mispredict), 32'd0);
    chk({tag, "_ill"}, 32'(o_illegal), 32'd0);
    chk({tag, "_cnt"}, 32'(o_mispred_count), 32'd0);
    chk({tag, "_cnt_w2"}, 32'(o2_mispred_count), 32'd0);
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_branch = 1'b0; i_branch_op = 3'b000;
    i_a = '0; i_b = '0; i_pc = '0; i_pred_take = 1'b0; i_flush = 1'b0; i_pred_pc = '0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    chk_outputs_zero("reset");
    chk_pred("pred_reset_100", 32'h100, 1'b0);

    // Counter at idx 0: 01 -> 10 -> 11 (saturates) -> 10 after BNE not-taken
    issue(1, 3'b000, 10, 10, 32'h100, 0, 0, 1, 1, 0, 1);
    idle();
    chk_pred("pred_100_after1", 32'h100, 1'b1);
    issue(1, 3'b000, 10, 10, 32'h100, 1, 0, 1, 0, 0, 1);
    issue(1, 3'b000, 10, 10, 32'h100, 1, 0, 1, 0, 0, 1);
    issue(1, 3'b000, 10, 10, 32'h100, 1, 0, 1, 0, 0, 1);
    idle();
    chk_pred("pred_100_sat", 32'h100, 1'b1);
    issue(1, 3'b001, 25, 25, 32'h100, 1, 0, 0, 1, 0, 2);
    idle();
    chk_pred("pred_100_after_bne", 32'h100, 1'b1);

    // Signed vs unsigned at idx 2: 01->10->01->10->01->00
    issue(1, 3'b100, 32'hFFFF_FFFF, 32'hF, 32'h108, 0, 0, 1, 1, 0, 3);
    issue(1, 3'b110, 32'hFFFF_FFFF, 32'hF, 32'h108, 0, 0, 0, 0, 0, 3);
    issue(1, 3'b111, 32'hFFFF_FFFF, 32'hF, 32'h108, 0, 0, 1, 1, 0, 4);
    issue(1, 3'b101, 32'hFFFF_FFFF, 32'hF, 32'h108, 0, 0, 0, 0, 0, 4);
    issue(1, 3'b100, 32'd5, 32'hFFFF_FFFD, 32'h108, 0, 0, 0, 0, 0, 4);
    idle();
    chk_pred("pred_108", 32'h108, 1'b0);

    // Update via alias 0x204 while predicting 0x104 (both idx 1)
    issue(1, 3'b000, 1, 1, 32'h204, 0, 0, 1, 1, 0, 5);
    chk_pred("pred_104_same_cycle", 32'h104, 1'b0);
    idle();
    chk_pred("pred_104_next", 32'h104, 1'b1);
    chk_pred("pred_204_alias", 32'h204, 1'b1);

    issue(1, 3'b010, 1, 1, 32'h104, 1, 0, 0, 0, 1, 5);
    idle();
    chk_pred("pred_104_after_illegal", 32'h104, 1'b1);

    // Non-branch with taken prediction: mispredict, no table update
    issue(0, 3'b001, 1, 1, 32'h104, 1, 0, 0, 1, 0, 6);
    idle();
    chk_pred("pred_104_after_nonbr", 32'h104, 1'b1);

    issue(1, 3'b001, 1, 1, 32'h104, 1, 1, 0, 0, 0, 0);
    idle();
    chk_pred("pred_104_after_flush", 32'h104, 1'b1);
    idle();

    // Reset while a result is visible, with another request in flight
    issue(1, 3'b000, 3, 3, 32'h100, 0, 0, 1, 1, 0, 7);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    i_valid = 1'b1;
    i_branch = 1'b1;
    i_branch_op = 3'b000;
    i_a = 9; i_b = 9; i_pc = 32'h104; i_pred_take = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    i_valid = 1'b0;
    i_branch = 1'b0;
    chk_outputs_zero("midrst");
    chk_pred("pred_100_rst", 32'h100, 1'b0);
    chk_pred("pred_104_rst", 32'h104, 1'b0);

    // Counter must be exactly 01: one taken update flips the prediction
    issue(1, 3'b000, 7, 7, 32'h104, 0, 0, 1, 1, 0, 1);
    idle();
    chk_pred("pred_104_post_rst", 32'h104, 1'b1);

    repeat (3) idle();
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
